// File: rtl/cv32e40p_instr_obi_arbiter.sv
// rtl/cv32e40p_instr_obi_arbiter.sv - two-requester instruction-side OBI arbiter with in-order response routing
// Optional round-robin conflict resolution: define CV32E40P_IARB_RR_EN (default build is fixed priority to m0).
module cv32e40p_instr_obi_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic [2:0]  outstanding_o,
  output logic        busy_o,
  output logic        protocol_err_o
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  logic [2:0]                 r_count;
  logic [MAX_OUTSTANDING-1:0] r_fifo;
  logic                       r_lock;
  logic                       r_owner;
  logic                       r_perr;
`ifdef CV32E40P_IARB_RR_EN
  logic                       r_last;
`endif

  logic                       w_owner;
  logic                       w_full;
  logic                       w_req;
  logic                       w_grant;
  logic                       w_pop;
  logic                       w_head;
  logic [2:0]                 w_wr_idx;
  logic [MAX_OUTSTANDING-1:0] w_shifted;

  always_comb begin
    w_owner = 1'b0;
    if (r_lock) begin
      w_owner = r_owner;
    end else if (m0_req_i && m1_req_i) begin
`ifdef CV32E40P_IARB_RR_EN
      w_owner = ~r_last;
`else
      w_owner = 1'b0;
`endif
    end else begin
      w_owner = m1_req_i & ~m0_req_i;
    end
  end

  assign w_full       = (r_count == MAX_CNT);
  assign w_req        = (w_owner ? m1_req_i : m0_req_i) & ~w_full;
  assign w_grant      = instr_gnt_i & w_req;
  assign w_pop        = instr_rvalid_i & (r_count != 3'd0);
  assign w_head       = r_fifo[0];
  assign w_shifted    = r_fifo >> 1;
  // Push slot accounts for a same-cycle pop shifting the queue down by one.
  assign w_wr_idx     = r_count - {2'b00, w_pop};

  assign instr_req_o  = w_req;
  assign instr_addr_o = w_owner ? m1_addr_i : m0_addr_i;
  assign m0_gnt_o     = w_grant & ~w_owner;
  assign m1_gnt_o     = w_grant & w_owner;
  assign m0_rvalid_o  = w_pop & ~w_head;
  assign m1_rvalid_o  = w_pop & w_head;
  assign m0_rdata_o   = instr_rdata_i;
  assign m1_rdata_o   = instr_rdata_i;
  assign m0_err_o     = instr_err_i & m0_rvalid_o;
  assign m1_err_o     = instr_err_i & m1_rvalid_o;
  assign outstanding_o  = r_count;
  assign busy_o         = m0_req_i | m1_req_i | (r_count != 3'd0);
  assign protocol_err_o = r_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 3'd0;
      r_fifo  <= '0;
      r_lock  <= 1'b0;
      r_owner <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      // Lock holds the request stable until granted; it also drops if the owner withdraws.
      r_lock <= w_req & ~instr_gnt_i;
      if (w_req && !instr_gnt_i) begin
        r_owner <= w_owner;
      end
      r_count <= r_count + {2'b00, w_grant} - {2'b00, w_pop};
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (w_grant && (w_wr_idx == 3'(i))) begin
          r_fifo[i] <= w_owner;
        end else if (w_pop) begin
          r_fifo[i] <= w_shifted[i];
        end
      end
      if (instr_rvalid_i && (r_count == 3'd0)) begin
        r_perr <= 1'b1;
      end
    end
  end

`ifdef CV32E40P_IARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_grant) begin
      r_last <= w_owner;
    end
  end
`endif

endmodule

// File: tb/tb_cv32e40p_instr_obi_arbiter.sv
// tb/tb_cv32e40p_instr_obi_arbiter.sv - self-checking bench for cv32e40p_instr_obi_arbiter (default fixed-priority build)
module tb_cv32e40p_instr_obi_arbiter;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
  logic [31:0] m0_addr_i = '0, m1_addr_i = '0;
  logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0, instr_err_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic [2:0]  outstanding_o;
  logic        busy_o, protocol_err_o;

  cv32e40p_instr_obi_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
    .outstanding_o(outstanding_o), .busy_o(busy_o), .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of requester IDs awaiting responses, plus pending-lock state.
  int   mq[$];
  bit   m_lock;
  int   m_lown;
  bit   m_perr;

  typedef struct {
    logic        m0r;
    logic [31:0] m0a;
    logic        m1r;
    logic [31:0] m1a;
    logic        gnt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_g0;
    logic        e_g1;
    logic        e_busy;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_lock = 1'b0;
    m_lown = 0;
    m_perr = 1'b0;
  endtask

  task automatic step(input logic m0r, input logic [31:0] m0a, input logic m1r, input logic [31:0] m1a,
                      input logic g, input logic rv, input logic [31:0] rd, input logic e);
    int  own;
    bit  ereq, pop;
    int  head;
    @(negedge clk);
    m0_req_i = m0r; m0_addr_i = m0a; m1_req_i = m1r; m1_addr_i = m1a;
    instr_gnt_i = g; instr_rvalid_i = rv; instr_rdata_i = rd; instr_err_i = e;
    #1;
    own  = m_lock ? m_lown : (m0r ? 0 : (m1r ? 1 : 0));
    ereq = ((own == 1) ? m1r : m0r) && (mq.size() < MAXO);
    pop  = rv && (mq.size() > 0);
    head = (mq.size() > 0) ? mq[0] : 0;
    chk("instr_req", instr_req_o, ereq);
    chk("instr_addr", instr_addr_o, (own == 1) ? m1a : m0a);
    chk("m0_gnt", m0_gnt_o, g && ereq && own == 0);
    chk("m1_gnt", m1_gnt_o, g && ereq && own == 1);
    chk("m0_rvalid", m0_rvalid_o, pop && head == 0);
    chk("m1_rvalid", m1_rvalid_o, pop && head == 1);
    chk("m0_err", m0_err_o, pop && head == 0 && e);
    chk("m1_err", m1_err_o, pop && head == 1 && e);
    chk("outstanding", outstanding_o, mq.size());
    chk("busy", busy_o, m0r || m1r || mq.size() != 0);
    chk("protocol_err", protocol_err_o, m_perr);
    if (pop) begin
      chk("m0_rdata", m0_rdata_o, rd);
      chk("m1_rdata", m1_rdata_o, rd);
    end
    if (rv && mq.size() == 0) m_perr = 1'b1;
    if (pop) void'(mq.pop_front());
    if (g && ereq) mq.push_back(own);
    m_lock = ereq && !g;
    if (m_lock) m_lown = own;
  endtask

  task automatic idle(input logic rv, input logic [31:0] rd, input logic e);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, rv, rd, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    m0_req_i = 1'b0; m1_req_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_err_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_outstanding", outstanding_o, 3'd0);
    chk("rst_protocol_err", protocol_err_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic m0r, input logic m1r, input logic g,
                              input logic er, input logic [31:0] ea, input logic eg0, input logic eg1, input logic eb);
    vec_t v;
    v.m0r = m0r; v.m0a = 32'h0000_0010; v.m1r = m1r; v.m1a = 32'h0000_0020; v.gnt = g;
    v.e_req = er; v.e_addr = ea; v.e_g0 = eg0; v.e_g1 = eg1; v.e_busy = eb;
    return v;
  endfunction

  initial begin
    vecs[0] = mk(0, 0, 0, 0, 32'h10, 0, 0, 0);
    vecs[1] = mk(1, 0, 1, 1, 32'h10, 1, 0, 1);
    vecs[2] = mk(0, 1, 1, 1, 32'h20, 0, 1, 1);
    vecs[3] = mk(1, 1, 1, 1, 32'h10, 1, 0, 1);
    vecs[4] = mk(1, 0, 0, 1, 32'h10, 0, 0, 1);
    vecs[5] = mk(0, 1, 0, 1, 32'h20, 0, 0, 1);
    vecs[6] = mk(1, 1, 0, 1, 32'h10, 0, 0, 1);
    vecs[7] = mk(0, 0, 1, 0, 32'h10, 0, 0, 0);

    model_reset();
    do_reset();

    // Single-cycle arbitration vectors from an idle, unlocked state.
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].m0r, vecs[i].m0a, vecs[i].m1r, vecs[i].m1a, vecs[i].gnt, 1'b0, 32'h0, 1'b0);
      chk($sformatf("vec%0d_req", i), instr_req_o, vecs[i].e_req);
      chk($sformatf("vec%0d_addr", i), instr_addr_o, vecs[i].e_addr);
      chk($sformatf("vec%0d_g0", i), m0_gnt_o, vecs[i].e_g0);
      chk($sformatf("vec%0d_g1", i), m1_gnt_o, vecs[i].e_g1);
      chk($sformatf("vec%0d_busy", i), busy_o, vecs[i].e_busy);
      idle(vecs[i].e_g0 | vecs[i].e_g1, 32'h0, 1'b0);
      idle(1'b0, 32'h0, 1'b0);
    end

    // Single m0 fetch.
    step(1, 32'h0000_1000, 0, 32'h0, 1, 0, 32'h0, 0);
    chk("fetch_gnt", m0_gnt_o, 1'b1);
    idle(1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("fetch_cnt1", outstanding_o, 3'd1);
    chk("fetch_rvalid", m0_rvalid_o, 1'b1);
    chk("fetch_rdata", m0_rdata_o, 32'hDEAD_BEEF);
    chk("fetch_m1_rvalid", m1_rvalid_o, 1'b0);
    idle(1'b0, 32'h0, 1'b0);
    chk("fetch_cnt0", outstanding_o, 3'd0);

    // Lock: address frozen while ungranted, late requester waits.
    for (int i = 0; i < 3; i++) step(1, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0);
    step(1, 32'h100, 1, 32'h300, 0, 0, 32'h0, 0);
    chk("lock_addr", instr_addr_o, 32'h100);
    chk("lock_m1_gnt", m1_gnt_o, 1'b0);
    step(1, 32'h100, 1, 32'h300, 1, 0, 32'h0, 0);
    chk("lock_m0_gnt", m0_gnt_o, 1'b1);
    step(0, 32'h0, 1, 32'h300, 1, 0, 32'h0, 0);
    chk("lock_m1_next", m1_gnt_o, 1'b1);
    idle(1, 32'h1, 0);
    idle(1, 32'h2, 0);

    // Outstanding limit.
    step(1, 32'h40, 0, 32'h0, 1, 0, 32'h0, 0);
    step(1, 32'h44, 0, 32'h0, 1, 0, 32'h0, 0);
    step(1, 32'h48, 0, 32'h0, 1, 1, 32'h5, 0);
    chk("full_req", instr_req_o, 1'b0);
    chk("full_cnt", outstanding_o, 3'd2);
    step(1, 32'h48, 0, 32'h0, 1, 0, 32'h0, 0);
    chk("refwd_req", instr_req_o, 1'b1);
    idle(1, 32'h6, 0);
    idle(1, 32'h7, 0);

    // Interleaved routing with error on the second response.
    step(1, 32'h200, 0, 32'h0, 1, 0, 32'h0, 0);
    step(0, 32'h0, 1, 32'h300, 1, 0, 32'h0, 0);
    idle(1, 32'hA, 0);
    chk("il_m0_rv", m0_rvalid_o, 1'b1);
    chk("il_m0_data", m0_rdata_o, 32'hA);
    idle(1, 32'hB, 1);
    chk("il_m1_rv", m1_rvalid_o, 1'b1);
    chk("il_m1_data", m1_rdata_o, 32'hB);
    chk("il_m1_err", m1_err_o, 1'b1);
    chk("il_m0_err", m0_err_o, 1'b0);

    // Conflict: fixed priority keeps granting m0.
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h500, 1, 32'h600, 1, (i != 0), 32'h0, 0);
      chk($sformatf("conf%0d_m0", i), m0_gnt_o, 1'b1);
      chk($sformatf("conf%0d_m1", i), m1_gnt_o, 1'b0);
    end
    idle(1, 32'h0, 0);

    // Randomized traffic against the model; responses only while something is outstanding.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)), (mq.size() > 0) && ($urandom_range(0, 1) == 1),
           $urandom, 1'($urandom_range(0, 1)));
    end
    while (mq.size() > 0) idle(1, 32'h0, 0);
    chk("rand_no_perr", protocol_err_o, 1'b0);

    // Stray response, sticky error, reset with transactions outstanding.
    idle(1, 32'h9, 0);
    chk("stray_m0_rv", m0_rvalid_o, 1'b0);
    chk("stray_m1_rv", m1_rvalid_o, 1'b0);
    idle(0, 32'h0, 0);
    chk("stray_perr", protocol_err_o, 1'b1);
    idle(0, 32'h0, 0);
    chk("stray_perr_hold", protocol_err_o, 1'b1);
    step(1, 32'h700, 0, 32'h0, 1, 0, 32'h0, 0);
    step(1, 32'h704, 0, 32'h0, 1, 0, 32'h0, 0);
    idle(0, 32'h0, 0);
    chk("pre_rst_cnt", outstanding_o, 3'd2);
    do_reset();
    step(0, 32'h0, 1, 32'h800, 0, 0, 32'h0, 0);
    chk("post_rst_nolock", instr_addr_o, 32'h800);
    idle(1, 32'h0, 0);
    idle(0, 32'h0, 0);
    chk("late_rv_perr", protocol_err_o, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
